tc_pl_cap_gain_seq: RTL and testbench



---
 rtl/tc_pl_cap_pkg.sv | 24 ++
 rtl/tc_pl_cap_tick.sv | 29 ++
 rtl/tc_pl_cap_gain_seq.sv | 143 ++++++++++++++
 tb/tb_tc_pl_cap_gain_seq.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tc_pl_cap_pkg.sv
// Shared widths, address stride and FSM state encoding for the per-gain capture sequencer.
package tc_pl_cap_pkg;

    localparam int DEF_CAP0_6    = 14;
    localparam int DEF_CAP0_7    = 32;
    localparam int DEF_CAP0_10   = 18;
    localparam int DEF_CAP0_11   = 32;
    localparam int DEF_ADDR_STEP = 16;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_DELAY = 3'd1;
    localparam logic [2:0] ST_CAPT  = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        DELAY = ST_DELAY,
        CAPT  = ST_CAPT,
        DRAIN = ST_DRAIN,
        DONE  = ST_DONE
    } cap_seq_state_t;

endpackage

// File: rtl/tc_pl_cap_tick.sv
// Reloadable down-counter producing the sample strobe: fires on the first enabled clock
// after load, then once every eff_cycle clocks.
module tc_pl_cap_tick #(
    parameter int CW = tc_pl_cap_pkg::DEF_CAP0_10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] eff_cycle,
    output logic          tick
);

    logic [CW-1:0] cnt;

    assign tick = !load && (cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (cnt == '0) begin
            cnt <= eff_cycle - CW'(1);
        end else begin
            cnt <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/tc_pl_cap_gain_seq.sv
// Per-gain capture sequencer: delay, strobed ADC sampling and valid/ready write beats.
// Optional abort input enabled by defining CAP_GAIN_SEQ_ABORT_EN.
module tc_pl_cap_gain_seq
    import tc_pl_cap_pkg::*;
#(
    parameter int CAP0_6    = DEF_CAP0_6,
    parameter int CAP0_7    = DEF_CAP0_7,
    parameter int CAP0_10   = DEF_CAP0_10,
    parameter int CAP0_11   = DEF_CAP0_11,
    parameter int DATA_W    = 16,
    parameter int ADDR_STEP = DEF_ADDR_STEP
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cap_trig,
    input  logic [CAP0_6-1:0]  cap_points,
    input  logic [CAP0_7-1:0]  cap_gain_addr,
    input  logic [CAP0_10-1:0] cap_gain_cycle,
    input  logic [CAP0_11-1:0] cap_gain_Lddel,
    input  logic [DATA_W-1:0]  adc_data,
`ifdef CAP_GAIN_SEQ_ABORT_EN
    input  logic               cap_abort,
`endif
    output logic               wr_valid,
    input  logic               wr_ready,
    output logic [CAP0_7-1:0]  wr_addr,
    output logic [DATA_W-1:0]  wr_data,
    output logic               cap_busy,
    output logic               cap_done,
    output logic               cap_ovf
);

    cap_seq_state_t     state;
    logic [CAP0_6-1:0]  pts_q;
    logic [CAP0_7-1:0]  addr_q;
    logic [CAP0_10-1:0] cycle_q;
    logic [CAP0_11-1:0] dly_cnt;
    logic [CAP0_10-1:0] eff_cycle;
    logic               strobe_raw;
    logic               strobe;
    logic               abort;
    logic               xfer;
    logic               last_pt;

`ifdef CAP_GAIN_SEQ_ABORT_EN
    assign abort = cap_abort && ((state == DELAY) || (state == CAPT));
`else
    assign abort = 1'b0;
`endif

    assign eff_cycle = (cycle_q == '0) ? CAP0_10'(1) : cycle_q;
    assign strobe    = strobe_raw && !abort;
    assign xfer      = wr_valid && wr_ready;
    assign last_pt   = (pts_q == CAP0_6'(1));
    assign cap_busy  = (state == DELAY) || (state == CAPT) || (state == DRAIN);

    tc_pl_cap_tick #(.CW(CAP0_10)) u_tick (
        .clk       (clk),
        .rst       (rst),
        .load      (state != CAPT),
        .eff_cycle (eff_cycle),
        .tick      (strobe_raw)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            pts_q    <= '0;
            addr_q   <= '0;
            cycle_q  <= '0;
            dly_cnt  <= '0;
            wr_valid <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            cap_done <= 1'b0;
            cap_ovf  <= 1'b0;
        end else begin
            cap_done <= (state == DONE);

            // A strobe landing on a stalled beat drops its sample but still consumes the point.
            if (strobe) begin
                if (wr_valid && !wr_ready) begin
                    cap_ovf <= 1'b1;
                end else begin
                    wr_valid <= 1'b1;
                    wr_addr  <= addr_q;
                    wr_data  <= adc_data;
                end
                addr_q <= addr_q + CAP0_7'(ADDR_STEP);
                pts_q  <= pts_q - CAP0_6'(1);
            end else if (xfer) begin
                wr_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (cap_trig) begin
                        pts_q   <= cap_points;
                        addr_q  <= cap_gain_addr;
                        cycle_q <= cap_gain_cycle;
                        dly_cnt <= cap_gain_Lddel;
                        cap_ovf <= 1'b0;
                        if (cap_points == '0) begin
                            state <= DONE;
                        end else if (cap_gain_Lddel <= CAP0_11'(1)) begin
                            state <= CAPT;
                        end else begin
                            state <= DELAY;
                        end
                    end
                end
                // Leaving one clock early lets the first strobe land exactly Lddel clocks after the trigger.
                DELAY: begin
                    dly_cnt <= dly_cnt - CAP0_11'(1);
                    if (abort) begin
                        state <= DONE;
                    end else if (dly_cnt == CAP0_11'(2)) begin
                        state <= CAPT;
                    end
                end
                CAPT: begin
                    if (abort) begin
                        state <= (wr_valid && !wr_ready) ? DRAIN : DONE;
                    end else if (strobe && last_pt) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (xfer) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tc_pl_cap_gain_seq.sv
// Directed scoreboard bench for tc_pl_cap_gain_seq; abort scenario runs when CAP_GAIN_SEQ_ABORT_EN is defined.
module tb_tc_pl_cap_gain_seq;

    typedef struct {
        logic [31:0] addr;
        logic [15:0] data;
        int          cyc;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cap_trig = 1'b0;
    logic [13:0] cap_points = '0;
    logic [31:0] cap_gain_addr = '0;
    logic [17:0] cap_gain_cycle = '0;
    logic [31:0] cap_gain_Lddel = '0;
    logic [15:0] adc_data = '0;
    logic        wr_ready = 1'b1;
`ifdef CAP_GAIN_SEQ_ABORT_EN
    logic        cap_abort = 1'b0;
`endif
    logic        wr_valid;
    logic [31:0] wr_addr;
    logic [15:0] wr_data;
    logic        cap_busy;
    logic        cap_done;
    logic        cap_ovf;

    beat_t sb[$];
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int busy_seen = 0;
    int valid_seen = 0;
    int unexpected = 0;
    int trig_cyc = 0;
    int exp_done = 0;
    int mark = 0;

    always #5 clk = ~clk;

    tc_pl_cap_gain_seq dut (
        .clk            (clk),
        .rst            (rst),
        .cap_trig       (cap_trig),
        .cap_points     (cap_points),
        .cap_gain_addr  (cap_gain_addr),
        .cap_gain_cycle (cap_gain_cycle),
        .cap_gain_Lddel (cap_gain_Lddel),
        .adc_data       (adc_data),
`ifdef CAP_GAIN_SEQ_ABORT_EN
        .cap_abort      (cap_abort),
`endif
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .cap_busy       (cap_busy),
        .cap_done       (cap_done),
        .cap_ovf        (cap_ovf)
    );

    function automatic logic [15:0] adcVal(input int n);
        return 16'(n * 37 + 11);
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Observes the values that the next rising edge will sample.
    task automatic monitorOutputs();
        beat_t b;
        if (cap_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (cap_busy) busy_seen++;
        if (wr_valid) valid_seen++;
        if (wr_valid && wr_ready) begin
            if (sb.size() == 0) begin
                unexpected++;
            end else begin
                b = sb.pop_front();
                checkOutput("beat_addr", 64'(wr_addr), 64'(b.addr));
                checkOutput("beat_data", 64'(wr_data), 64'(b.data));
                checkOutput("beat_cycle", 64'(cyc), 64'(b.cyc));
            end
        end
    endtask

    task automatic stepClk();
        monitorOutputs();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        adc_data = adcVal(cyc);
    endtask

    // Triggers a capture; with push set, queues the beats expected under wr_ready held high.
    task automatic applyStimulus(input int points, input logic [31:0] addr, input int cycle,
                                 input int lddel, input bit push);
        int first;
        int eff;
        int e;
        cap_points     = 14'(points);
        cap_gain_addr  = addr;
        cap_gain_cycle = 18'(cycle);
        cap_gain_Lddel = 32'(lddel);
        cap_trig       = 1'b1;
        trig_cyc       = cyc + 1;
        first          = trig_cyc + ((lddel <= 1) ? 1 : lddel);
        eff            = (cycle == 0) ? 1 : cycle;
        if (points == 0) begin
            exp_done = trig_cyc + 1;
        end else begin
            exp_done = first + (points - 1) * eff + 2;
            if (push) begin
                for (int k = 0; k < points; k++) begin
                    e = first + k * eff;
                    sb.push_back('{addr + 32'(16 * k), adcVal(e - 1), e});
                end
            end
        end
        stepClk();
        cap_trig = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int budget);
        int start;
        start = done_cnt;
        for (int i = 0; i < budget && done_cnt == start; i++) begin
            stepClk();
        end
        checkOutput({tag, "_done_cycle"}, 64'(done_cyc), 64'(exp_done));
        checkOutput({tag, "_done_width"}, 64'(cap_done), 64'(0));
        checkOutput({tag, "_beats_left"}, 64'(sb.size()), 64'(0));
        checkOutput({tag, "_unexpected"}, 64'(unexpected), 64'(0));
    endtask

    initial begin
        adc_data = adcVal(0);
        #1;
        checkOutput("rst_wr_valid", 64'(wr_valid), 64'(0));
        checkOutput("rst_wr_addr", 64'(wr_addr), 64'(0));
        checkOutput("rst_wr_data", 64'(wr_data), 64'(0));
        checkOutput("rst_cap_busy", 64'(cap_busy), 64'(0));
        checkOutput("rst_cap_done", 64'(cap_done), 64'(0));
        checkOutput("rst_cap_ovf", 64'(cap_ovf), 64'(0));
        stepClk();
        stepClk();
        rst = 1'b0;
        stepClk();

        $display("[TB] delayed capture: 4 points, Lddel=10, cycle=5");
        applyStimulus(4, 32'h0000_0100, 5, 10, 1'b1);
        checkOutput("t1_busy_in_delay", 64'(cap_busy), 64'(1));
        waitDone("t1", 100);
        checkOutput("t1_ovf", 64'(cap_ovf), 64'(0));

        $display("[TB] back-to-back capture: 3 points, Lddel=0, cycle=0");
        applyStimulus(3, 32'h0000_0A00, 0, 0, 1'b1);
        waitDone("t2", 50);

        $display("[TB] stalled writer: 3 points, cycle=2, wr_ready low");
        wr_ready = 1'b0;
        applyStimulus(3, 32'h0000_2000, 2, 0, 1'b0);
        for (int i = 1; i <= 7; i++) begin
            stepClk();
            checkOutput("t3_hold_valid", 64'(wr_valid), 64'(1));
            checkOutput("t3_hold_addr", 64'(wr_addr), 64'(32'h0000_2000));
            checkOutput("t3_hold_data", 64'(wr_data), 64'(adcVal(trig_cyc)));
            if (i == 2) checkOutput("t3_ovf_before_drop", 64'(cap_ovf), 64'(0));
        end
        checkOutput("t3_ovf_after_drop", 64'(cap_ovf), 64'(1));
        checkOutput("t3_busy_drain", 64'(cap_busy), 64'(1));
        sb.push_back('{32'h0000_2000, adcVal(trig_cyc), cyc});
        exp_done = cyc + 2;
        wr_ready = 1'b1;
        waitDone("t3", 20);
        checkOutput("t3_ovf_sticky", 64'(cap_ovf), 64'(1));

        $display("[TB] address wrap: 2 points from 0xFFFFFFF0");
        applyStimulus(2, 32'hFFFF_FFF0, 1, 3, 1'b1);
        checkOutput("t5_ovf_cleared", 64'(cap_ovf), 64'(0));
        waitDone("t5", 50);

        $display("[TB] zero-point capture");
        busy_seen = 0;
        mark = valid_seen;
        applyStimulus(0, 32'h0000_3000, 4, 6, 1'b1);
        waitDone("t4", 20);
        for (int i = 0; i < 4; i++) stepClk();
        checkOutput("t4_busy_seen", 64'(busy_seen), 64'(0));
        checkOutput("t4_valid_seen", 64'(valid_seen - mark), 64'(0));

        $display("[TB] reset during an 8-point capture");
        applyStimulus(8, 32'h0000_4000, 3, 0, 1'b1);
        for (int i = 0; i < 4; i++) stepClk();
        checkOutput("t6_mid_beat_valid", 64'(wr_valid), 64'(1));
        rst = 1'b1;
        #1;
        checkOutput("t6_async_valid", 64'(wr_valid), 64'(0));
        checkOutput("t6_async_busy", 64'(cap_busy), 64'(0));
        checkOutput("t6_async_addr", 64'(wr_addr), 64'(0));
        checkOutput("t6_async_data", 64'(wr_data), 64'(0));
        sb.delete();
        mark = done_cnt;
        busy_seen = valid_seen;
        stepClk();
        stepClk();
        rst = 1'b0;
        for (int i = 0; i < 30; i++) stepClk();
        checkOutput("t6_no_done", 64'(done_cnt - mark), 64'(0));
        checkOutput("t6_no_valid", 64'(valid_seen - busy_seen), 64'(0));
        applyStimulus(2, 32'h0000_5000, 2, 4, 1'b1);
        waitDone("t6_rerun", 50);

`ifdef CAP_GAIN_SEQ_ABORT_EN
        $display("[TB] abort on second strobe of a 5-point capture");
        mark = valid_seen;
        applyStimulus(5, 32'h0000_6000, 3, 0, 1'b0);
        sb.push_back('{32'h0000_6000, adcVal(trig_cyc), trig_cyc + 1});
        stepClk();
        stepClk();
        stepClk();
        cap_abort = 1'b1;
        stepClk();
        cap_abort = 1'b0;
        exp_done = trig_cyc + 5;
        waitDone("t7", 30);
        checkOutput("t7_one_beat", 64'(valid_seen - mark), 64'(1));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
